// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the register file's single write port: valid/ready grant, registered write,
// starvation watchdog and protocol check. Define ARB_FIXED_PRI_EN for fixed priority (req0 wins ties).
module rf_wr_arbiter #(
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_grant,
    output logic              err
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              last_grant_q, last_grant_d;
    logic              err_q, err_d;

    logic              pick1;
    logic [1:0]        vld;
    logic [1:0]        xfer;
    logic [1:0]        flag;
    logic [SEL_W-1:0]  sel_a  [2];
    logic [DATA_W-1:0] data_a [2];

    assign vld[0]    = req0_valid;
    assign vld[1]    = req1_valid;
    assign sel_a[0]  = req0_sel;
    assign sel_a[1]  = req1_sel;
    assign data_a[0] = req0_data;
    assign data_a[1] = req1_data;

    // pick1 selects requester 1 whenever it is the requester to serve, ignoring hold.
    always_comb begin
        pick1 = 1'b0;
`ifdef ARB_FIXED_PRI_EN
        pick1 = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            pick1 = ~last_grant_q;
        end else begin
            pick1 = req1_valid;
        end
`endif
    end

    assign req0_ready = ~hold & req0_valid & ~pick1;
    assign req1_ready = ~hold & req1_valid & pick1;
    assign xfer[0]    = req0_ready;
    assign xfer[1]    = req1_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [3:0]        cnt_q, cnt_d;
            logic              pend_q, pend_d;
            logic [SEL_W-1:0]  psel_q;
            logic [DATA_W-1:0] pdata_q;
            logic              viol;

            always_comb begin
                cnt_d = 4'd0;
                if (vld[gi] && !xfer[gi]) begin
                    cnt_d = (cnt_q == WAIT_LIMIT) ? cnt_q : cnt_q + 4'd1;
                end
            end

            // A request left waiting must reappear unchanged on the following cycle.
            assign pend_d   = vld[gi] & ~xfer[gi];
            assign viol     = pend_q & (~vld[gi] | (sel_a[gi] != psel_q) | (data_a[gi] != pdata_q));
            assign flag[gi] = viol | (cnt_d == WAIT_LIMIT);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q   <= 4'd0;
                    pend_q  <= 1'b0;
                    psel_q  <= '0;
                    pdata_q <= '0;
                end else begin
                    cnt_q   <= cnt_d;
                    pend_q  <= pend_d;
                    psel_q  <= sel_a[gi];
                    pdata_q <= data_a[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (|flag);
        if (req0_ready) begin
            wr_en_d      = 1'b1;
            wr_sel_d     = req0_sel;
            wr_data_d    = req0_data;
            last_grant_d = 1'b0;
        end else if (req1_ready) begin
            wr_en_d      = 1'b1;
            wr_sel_d     = req1_sel;
            wr_data_d    = req1_data;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;
    assign err        = err_q;

endmodule
